// File: rtl/gemm_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gemm_drain_pkg
// Purpose : Shared types and helpers for the PE result-chain drain logic.
//           Holds the drain FSM state encoding and the shift-count width
//           helper used to size the counter in drain_shift_ctrl.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package gemm_drain_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // The counter must be able to represent CHAIN_LEN itself (terminal
    // value), hence the +1 inside the log.
    function automatic int DRAIN_CNT_W(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage : gemm_drain_pkg
`default_nettype wire

// File: rtl/drain_shift_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : drain_shift_ctrl_if
// Purpose : Ready/valid output stream carrying drained chain words.
// Ports   : out_data  - drained word at FIFO head
//           out_valid - out_data holds a valid word
//           out_ready - consumer accepts the word this cycle
//           out_last  - word is the final word of the drain
//           master modport: producer (drain_shift_ctrl)
//           slave  modport: consumer
// Rev     : 1.0  initial release
// ============================================================================
interface drain_shift_ctrl_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface : drain_shift_ctrl_if
`default_nettype wire

// File: rtl/drain_fifo.sv
`default_nettype none
// ============================================================================
// Module  : drain_fifo
// Purpose : Synchronous first-word-fall-through FIFO buffering drained words
//           (data plus last flag). The head entry is visible on o_head_data
//           whenever the FIFO is non-empty; when empty the head reads zero.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           i_push         - write i_push_data (ignored when full)
//           i_push_data    - entry to write
//           o_full         - no free entry
//           i_pop          - discard head entry (ignored when empty)
//           o_empty        - no valid entry
//           o_head_data    - head entry (zero when empty)
// Rev     : 1.0  initial release
// ============================================================================
module drain_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    output logic                  o_full,
    input  wire logic             i_pop,
    output logic                  o_empty,
    output logic [WIDTH-1:0]      o_head_data
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    logic [c_AW-1:0]  w_wr_addr;
    logic [c_AW-1:0]  w_rd_addr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_wr_addr = r_wr_ptr[c_AW-1:0];
    assign w_rd_addr = r_rd_ptr[c_AW-1:0];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (w_wr_addr == w_rd_addr);

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head output is masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_addr] <= i_push_data;
        end
    end

    assign o_head_data = o_empty ? '0 : r_mem[w_rd_addr];

endmodule : drain_fifo
`default_nettype wire

// File: rtl/drain_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : drain_shift_ctrl
// Purpose : Drains a CHAIN_LEN-stage PE result shift chain into a ready/valid
//           stream. On start, the chain is shifted one word per cycle while
//           the output FIFO has room; each tail word is captured into the
//           FIFO on the same edge. The final word is tagged last and done
//           pulses once it has been accepted downstream.
// Ports   : clk       - clock (rising edge)
//           rst       - synchronous active-high reset
//           start     - single-cycle drain request (honoured only when idle)
//           busy      - drain in progress (through the done cycle)
//           shift_ena - enable to every stage of the result chain
//           chain_out - tail-stage output of the result chain
//           done      - one-cycle pulse after the last word is transferred
//           out_if    - output stream (data / valid / ready / last)
// Rev     : 1.0  initial release
// ============================================================================
module drain_shift_ctrl
    import gemm_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHAIN_LEN  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       shift_ena,
    input  wire logic [DATA_WIDTH-1:0] chain_out,
    output logic                       done,
    drain_shift_ctrl_if.master         out_if
);

    localparam int                 c_CNT_W    = DRAIN_CNT_W(CHAIN_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_END  = c_CNT_W'(CHAIN_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CHAIN_LEN - 1);

    drain_state_t        r_state;
    drain_state_t        w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    logic                w_push_last;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [DATA_WIDTH:0] w_head;

    // ------------------------------------------------------------------
    // State and shift-count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode. shift_ena depends only on state,
    // count and FIFO full so there is no combinational path from the
    // downstream ready back into the chain enables.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        shift_ena   = 1'b0;
        w_push_last = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                end
            end

            ST_SHIFT: begin
                if ((r_cnt < c_CNT_END) && !w_fifo_full) begin
                    shift_ena = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_push_last = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                // Only the last-tagged entry ends the flush; earlier words
                // may still be queued ahead of it.
                if (w_pop && w_head[DATA_WIDTH]) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    assign w_pop = out_if.out_valid && out_if.out_ready;

    drain_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_drain_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (shift_ena),
        .i_push_data ({w_push_last, chain_out}),
        .o_full      (w_fifo_full),
        .i_pop       (w_pop),
        .o_empty     (w_fifo_empty),
        .o_head_data (w_head)
    );

    assign out_if.out_valid = !w_fifo_empty;
    assign out_if.out_data  = w_head[DATA_WIDTH-1:0];
    assign out_if.out_last  = w_head[DATA_WIDTH];

endmodule : drain_shift_ctrl
`default_nettype wire

// File: tb/tb_drain_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_drain_shift_ctrl
// Purpose : Self-checking bench for drain_shift_ctrl (CHAIN_LEN=4,
//           FIFO_DEPTH=2). A small chain model feeds chain_out; expected
//           words are queued when the chain is loaded and compared against
//           each output transfer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_drain_shift_ctrl;

    localparam int DW = 16;
    localparam int CL = 4;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          shift_ena;
    logic          done;
    logic [DW-1:0] chain_out;
    logic [DW-1:0] chain [CL];

    drain_shift_ctrl_if #(.DATA_WIDTH(DW)) out_if ();

    drain_shift_ctrl #(
        .DATA_WIDTH (DW),
        .CHAIN_LEN  (CL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .shift_ena (shift_ena),
        .chain_out (chain_out),
        .done      (done),
        .out_if    (out_if)
    );

    always #5 clk = ~clk;

    assign chain_out = chain[0];

    int          checks = 0;
    int          errors = 0;
    logic [DW:0] exp_q [$];

    int cyc        = 0;
    int n_shift    = 0;
    int n_xfer     = 0;
    int n_done     = 0;
    int n_busy_low = 0;
    int run_len    = 0;
    int max_run    = 0;
    int last_idx   = -1;
    int done_idx   = -2;
    bit toggle_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load the chain model (index 0 is the tail) and queue the words it
    // must produce, in tail order, with the final one tagged last.
    task automatic load_chain(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                              input logic [DW-1:0] v2, input logic [DW-1:0] v3);
        chain[0] = v0;
        chain[1] = v1;
        chain[2] = v2;
        chain[3] = v3;
        exp_q.push_back({1'b0, v0});
        exp_q.push_back({1'b0, v1});
        exp_q.push_back({1'b0, v2});
        exp_q.push_back({1'b1, v3});
    endtask

    task automatic clr_stats();
        n_shift    = 0;
        n_xfer     = 0;
        n_done     = 0;
        n_busy_low = 0;
        run_len    = 0;
        max_run    = 0;
        last_idx   = -1;
        done_idx   = -2;
    endtask

    // Observe the current cycle, then advance one clock edge.
    task automatic cycle();
        logic        se;
        logic        xf;
        logic [DW:0] e;
        se = shift_ena;
        xf = out_if.out_valid && out_if.out_ready;
        if (se === 1'b1) begin
            n_shift++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (busy === 1'b0) n_busy_low++;
        if (done === 1'b1) begin
            n_done++;
            done_idx = cyc;
        end
        if (xf === 1'b1) begin
            n_xfer++;
            chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_if.out_data), 32'(e[DW-1:0]));
                chk("out_last", 32'(out_if.out_last), 32'(e[DW]));
                if (e[DW]) last_idx = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (se === 1'b1) begin
            for (int i = 0; i < CL - 1; i++) chain[i] = chain[i+1];
            chain[CL-1] = 16'hDEAD;
        end
        if (toggle_ready) out_if.out_ready = !out_if.out_ready;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int i;
        int d0;
        i  = 0;
        d0 = n_done;
        while (n_done == d0 && i < budget) begin
            cycle();
            i++;
        end
        chk("done_within_budget", 32'(n_done != d0), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < CL; i++) chain[i] = '0;
        rst              = 1'b1;
        start            = 1'b1;
        out_if.out_ready = 1'b1;
        repeat (3) cycle();

        // Reset state (start held with rst must be ignored)
        chk("rst_busy",      32'(busy),             32'd0);
        chk("rst_shift_ena", 32'(shift_ena),        32'd0);
        chk("rst_out_valid", 32'(out_if.out_valid), 32'd0);
        chk("rst_out_last",  32'(out_if.out_last),  32'd0);
        chk("rst_done",      32'(done),             32'd0);
        chk("rst_out_data",  32'(out_if.out_data),  32'd0);
        rst   = 1'b0;
        start = 1'b0;
        cycle();
        chk("start_during_rst_ignored", 32'(busy), 32'd0);

        // Basic drain, ready always high
        clr_stats();
        load_chain(16'h11, 16'h22, 16'h33, 16'h44);
        pulse_start();
        chk("t1_busy",      32'(busy),             32'd1);
        chk("t1_shift_ena", 32'(shift_ena),        32'd1);
        chk("t1_valid_lat", 32'(out_if.out_valid), 32'd0);
        run_until_done(30);
        chk("t1_consec_shift", 32'(max_run),      32'd4);
        chk("t1_n_shift",      32'(n_shift),      32'd4);
        chk("t1_n_xfer",       32'(n_xfer),       32'd4);
        chk("t1_done_timing",  32'(done_idx),     32'(last_idx + 1));
        chk("t1_sb_empty",     32'(exp_q.size()), 32'd0);
        cycle();
        cycle();
        chk("t1_single_done", 32'(n_done), 32'd1);
        chk("t1_idle_busy",   32'(busy),   32'd0);

        // Back-pressure: FIFO fills after 2 shifts, then resumes
        clr_stats();
        out_if.out_ready = 1'b0;
        load_chain(16'hA1, 16'hA2, 16'hA3, 16'hA4);
        pulse_start();
        repeat (8) cycle();
        chk("t2_stall_shifts", 32'(n_shift),          32'd2);
        chk("t2_stall_ena",    32'(shift_ena),        32'd0);
        chk("t2_stall_valid",  32'(out_if.out_valid), 32'd1);
        chk("t2_stall_head",   32'(out_if.out_data),  32'h00A1);
        chk("t2_sb_pending",   32'(exp_q.size()),     32'd4);
        out_if.out_ready = 1'b1;
        run_until_done(30);
        chk("t2_n_shift",  32'(n_shift),      32'd4);
        chk("t2_n_xfer",   32'(n_xfer),       32'd4);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Toggling ready
        clr_stats();
        load_chain(16'hB1, 16'hB2, 16'hB3, 16'hB4);
        pulse_start();
        toggle_ready = 1'b1;
        run_until_done(40);
        toggle_ready     = 1'b0;
        out_if.out_ready = 1'b1;
        chk("t3_n_shift",  32'(n_shift),      32'd4);
        chk("t3_n_xfer",   32'(n_xfer),       32'd4);
        chk("t3_n_done",   32'(n_done),       32'd1);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // start re-pulsed while busy
        clr_stats();
        load_chain(16'hC1, 16'hC2, 16'hC3, 16'hC4);
        pulse_start();
        cycle();
        pulse_start();
        run_until_done(30);
        repeat (3) cycle();
        chk("t4_n_xfer",   32'(n_xfer),       32'd4);
        chk("t4_n_done",   32'(n_done),       32'd1);
        chk("t4_busy_end", 32'(busy),         32'd0);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-drain after the second shift
        clr_stats();
        out_if.out_ready = 1'b0;
        load_chain(16'hD1, 16'hD2, 16'hD3, 16'hD4);
        pulse_start();
        cycle();
        cycle();
        chk("t5_pre_rst_shifts", 32'(n_shift), 32'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_abort_valid", 32'(out_if.out_valid), 32'd0);
        chk("t5_abort_busy",  32'(busy),             32'd0);
        chk("t5_abort_ena",   32'(shift_ena),        32'd0);
        exp_q.delete();
        repeat (2) cycle();
        chk("t5_abort_no_done", 32'(n_done), 32'd0);
        clr_stats();
        out_if.out_ready = 1'b1;
        for (int i = 0; i < CL; i++) chain[i] = '0;
        load_chain(16'hE1, 16'hE2, 16'hE3, 16'hE4);
        pulse_start();
        run_until_done(30);
        chk("t5_fresh_shift", 32'(n_shift),      32'd4);
        chk("t5_fresh_xfer",  32'(n_xfer),       32'd4);
        chk("t5_sb_empty",    32'(exp_q.size()), 32'd0);

        // Back-to-back drains: start in the cycle after done
        clr_stats();
        load_chain(16'hF1, 16'hF2, 16'hF3, 16'hF4);
        pulse_start();
        run_until_done(30);
        load_chain(16'h51, 16'h52, 16'h53, 16'h54);
        pulse_start();
        n_busy_low = 0;
        run_until_done(30);
        chk("t6_busy_throughout", 32'(n_busy_low),   32'd0);
        chk("t6_n_xfer",          32'(n_xfer),       32'd8);
        chk("t6_n_done",          32'(n_done),       32'd2);
        chk("t6_sb_empty",        32'(exp_q.size()), 32'd0);

        repeat (2) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_drain_shift_ctrl
`default_nettype wire
